// File: rtl/pc_file_rr.sv
// rtl/pc_file_rr.sv - multi-task round-robin program counter file for fetch
//
// Holds one halfword-aligned PC per hardware task. Each cycle it presents one
// fetch address for the current task, then hands over to the next active task.
// Bit 0 of every address is always zero.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   a_rst      in   asynchronous active-low reset
//   hold       in   freeze fetch: no increment, no scheduler advance, prev kept
//   ws         in   redirect strobe
//   w_ts       in   task to redirect
//   i_pc       in   redirect target (bit 0 ignored)
//   start      in   task start strobe
//   start_ts   in   task to start
//   start_pc   in   first fetch address of the started task (bit 0 ignored)
//   stop       in   task stop strobe
//   stop_ts    in   task to stop
//   o_valid    out  o_pc is a real fetch this cycle
//   o_ts       out  task issuing o_pc
//   o_pc       out  fetch address
//   o_prev_ts  out  task of the last accepted fetch
//   o_prev_pc  out  address of the last accepted fetch
//   o_active   out  active-task mask
module pc_file_rr #(
  parameter  int ADDR_W = 16,
  parameter  int TASKS  = 4,
  localparam int TS_W   = $clog2(TASKS)
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              hold,
  input  logic              ws,
  input  logic [TS_W-1:0]   w_ts,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              start,
  input  logic [TS_W-1:0]   start_ts,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              stop,
  input  logic [TS_W-1:0]   stop_ts,
  output logic              o_valid,
  output logic [TS_W-1:0]   o_ts,
  output logic [ADDR_W-1:0] o_pc,
  output logic [TS_W-1:0]   o_prev_ts,
  output logic [ADDR_W-1:0] o_prev_pc,
  output logic [TASKS-1:0]  o_active
);

  localparam int PW = ADDR_W - 1;

  // Each pc holds "next fetch minus one" in halfword units, so the address
  // presented is always pc+1. Reset to all-ones makes the first fetch 0.
  logic [PW-1:0]     pc_q [TASKS];
  logic [PW-1:0]     pc_d [TASKS];
  logic [TASKS-1:0]  active_q, active_d;
  logic [TS_W-1:0]   cur_q, cur_d;
  logic [TS_W-1:0]   prev_ts_q, prev_ts_d;
  logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;

  logic              accept;
  logic [PW-1:0]     pc_inc;
  logic [TASKS-1:0]  start_bit;
  logic [TASKS-1:0]  stop_bit;
  logic [TS_W-1:0]   idx;
  logic              found;
  logic              unused_lsbs;

  assign unused_lsbs = ^{i_pc[0], start_pc[0]};

  assign pc_inc    = pc_q[cur_q] + PW'(1);
  assign o_valid   = active_q[cur_q];
  assign o_ts      = cur_q;
  assign o_pc      = {pc_inc, 1'b0};
  assign o_prev_ts = prev_ts_q;
  assign o_prev_pc = prev_pc_q;
  assign o_active  = active_q;

  assign accept = o_valid & ~hold;

  always_comb begin
    start_bit = '0;
    stop_bit  = '0;
    for (int t = 0; t < TASKS; t++) begin
      start_bit[t] = start && (start_ts == TS_W'(t));
      stop_bit[t]  = stop  && (stop_ts  == TS_W'(t));
      pc_d[t]      = pc_q[t];
      // Priority: start (unless stopped the same cycle) > redirect > increment.
      if (start_bit[t] && !stop_bit[t]) begin
        pc_d[t] = start_pc[ADDR_W-1:1] - PW'(1);
      end else if (ws && (w_ts == TS_W'(t))) begin
        pc_d[t] = i_pc[ADDR_W-1:1] - PW'(1);
      end else if (accept && (cur_q == TS_W'(t))) begin
        pc_d[t] = pc_inc;
      end
    end

    active_d = (active_q | start_bit) & ~stop_bit;

    // Round-robin: scan cur+1 .. cur+TASKS, so cur itself is considered last
    // and a lone active task is re-selected every cycle.
    cur_d = cur_q;
    idx   = '0;
    found = 1'b0;
    if (!hold) begin
      for (int k = 1; k <= TASKS; k++) begin
        idx = cur_q + TS_W'(k);
        if (!found && active_d[idx]) begin
          cur_d = idx;
          found = 1'b1;
        end
      end
    end

    prev_ts_d = prev_ts_q;
    prev_pc_d = prev_pc_q;
    if (accept) begin
      prev_ts_d = cur_q;
      prev_pc_d = o_pc;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int t = 0; t < TASKS; t++) begin
        pc_q[t] <= '1;
      end
      active_q  <= TASKS'(1);
      cur_q     <= '0;
      prev_ts_q <= '0;
      prev_pc_q <= '0;
    end else begin
      for (int t = 0; t < TASKS; t++) begin
        pc_q[t] <= pc_d[t];
      end
      active_q  <= active_d;
      cur_q     <= cur_d;
      prev_ts_q <= prev_ts_d;
      prev_pc_q <= prev_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_file_rr.sv
// tb/tb_pc_file_rr.sv - self-checking bench for pc_file_rr
module tb_pc_file_rr;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        hold = 1'b0;
  logic        ws = 1'b0;
  logic [1:0]  w_ts = 2'd0;
  logic [15:0] i_pc = 16'h0;
  logic        start = 1'b0;
  logic [1:0]  start_ts = 2'd0;
  logic [15:0] start_pc = 16'h0;
  logic        stop = 1'b0;
  logic [1:0]  stop_ts = 2'd0;
  logic        o_valid;
  logic [1:0]  o_ts;
  logic [15:0] o_pc;
  logic [1:0]  o_prev_ts;
  logic [15:0] o_prev_pc;
  logic [3:0]  o_active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_file_rr #(.ADDR_W(16), .TASKS(4)) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .hold      (hold),
    .ws        (ws),
    .w_ts      (w_ts),
    .i_pc      (i_pc),
    .start     (start),
    .start_ts  (start_ts),
    .start_pc  (start_pc),
    .stop      (stop),
    .stop_ts   (stop_ts),
    .o_valid   (o_valid),
    .o_ts      (o_ts),
    .o_pc      (o_pc),
    .o_prev_ts (o_prev_ts),
    .o_prev_pc (o_prev_pc),
    .o_active  (o_active)
  );

  typedef struct {
    logic        v;
    logic [1:0]  ts;
    logic [15:0] pc;
    logic [1:0]  pts;
    logic [15:0] ppc;
    logic [3:0]  act;
  } exp_t;

  typedef struct {
    logic        hold;
    logic        ws;
    logic [1:0]  w_ts;
    logic [15:0] i_pc;
    logic        start;
    logic [1:0]  start_ts;
    logic [15:0] start_pc;
    logic        stop;
    logic [1:0]  stop_ts;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[26];

  function automatic vec_t mk(
    input logic h, input logic w, input logic [1:0] wts, input logic [15:0] ipc,
    input logic st, input logic [1:0] sts, input logic [15:0] spc,
    input logic sp, input logic [1:0] spts,
    input logic v, input logic [1:0] ts, input logic [15:0] pc,
    input logic [1:0] pts, input logic [15:0] ppc, input logic [3:0] act);
    vec_t r;
    r.hold = h; r.ws = w; r.w_ts = wts; r.i_pc = ipc;
    r.start = st; r.start_ts = sts; r.start_pc = spc;
    r.stop = sp; r.stop_ts = spts;
    r.e.v = v; r.e.ts = ts; r.e.pc = pc; r.e.pts = pts; r.e.ppc = ppc; r.e.act = act;
    return r;
  endfunction

  function automatic exp_t mke(input logic v, input logic [1:0] ts, input logic [15:0] pc,
                               input logic [1:0] pts, input logic [15:0] ppc, input logic [3:0] act);
    exp_t e;
    e.v = v; e.ts = ts; e.pc = pc; e.pts = pts; e.ppc = ppc; e.act = act;
    return e;
  endfunction

  task automatic chk(input string tag, input string what, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "o_valid",   16'(o_valid),   16'(e.v));
      chk(tag, "o_ts",      16'(o_ts),      16'(e.ts));
      chk(tag, "o_pc",      o_pc,           e.pc);
      chk(tag, "o_prev_ts", 16'(o_prev_ts), 16'(e.pts));
      chk(tag, "o_prev_pc", o_prev_pc,      e.ppc);
      chk(tag, "o_active",  16'(o_active),  16'(e.act));
    end
  endtask

  task automatic clear_inputs();
    hold = 1'b0; ws = 1'b0; w_ts = 2'd0; i_pc = 16'h0;
    start = 1'b0; start_ts = 2'd0; start_pc = 16'h0;
    stop = 1'b0; stop_ts = 2'd0;
  endtask

  // Inputs held for exactly one rising edge; outputs are register-only, so the
  // expected values describe state before that edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    hold = v.hold; ws = v.ws; w_ts = v.w_ts; i_pc = v.i_pc;
    start = v.start; start_ts = v.start_ts; start_pc = v.start_pc;
    stop = v.stop; stop_ts = v.stop_ts;
    sb.push_back(v.e);
    #1;
    compare_front(tag);
  endtask

  initial begin
    // h  ws wts ipc        st sts spc        sp spts  v  ts  pc         pts ppc        act
    tbl[0]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd0,16'h0000,2'd0,16'h0000,4'h1);
    tbl[1]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b1,2'd2,16'h0100, 1'b0,2'd0, 1'b1,2'd0,16'h0002,2'd0,16'h0000,4'h1);
    tbl[2]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd2,16'h0100,2'd0,16'h0002,4'h5);
    tbl[3]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b1,2'd1,16'h0200, 1'b0,2'd0, 1'b1,2'd0,16'h0004,2'd2,16'h0100,4'h5);
    tbl[4]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b1,2'd3,16'h0300, 1'b0,2'd0, 1'b1,2'd1,16'h0200,2'd0,16'h0004,4'h7);
    tbl[5]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd2,16'h0102,2'd1,16'h0200,4'hF);
    tbl[6]  = mk(1'b1,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0300,2'd2,16'h0102,4'hF);
    tbl[7]  = mk(1'b1,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0300,2'd2,16'h0102,4'hF);
    tbl[8]  = mk(1'b1,1'b1,2'd1,16'h4000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0300,2'd2,16'h0102,4'hF);
    tbl[9]  = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0300,2'd2,16'h0102,4'hF);
    tbl[10] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd0,16'h0006,2'd3,16'h0300,4'hF);
    tbl[11] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd2, 1'b1,2'd1,16'h4000,2'd0,16'h0006,4'hF);
    tbl[12] = mk(1'b0,1'b1,2'd2,16'h0800, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0302,2'd1,16'h4000,4'hB);
    tbl[13] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd1, 1'b1,2'd0,16'h0008,2'd3,16'h0302,4'hB);
    tbl[14] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd0, 1'b1,2'd3,16'h0304,2'd0,16'h0008,4'h9);
    tbl[15] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd3, 1'b1,2'd3,16'h0306,2'd3,16'h0304,4'h8);
    tbl[16] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b0,2'd3,16'h0308,2'd3,16'h0306,4'h0);
    tbl[17] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b1,2'd3,16'h0010, 1'b0,2'd0, 1'b0,2'd3,16'h0308,2'd3,16'h0306,4'h0);
    tbl[18] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b1,2'd1,16'h0040, 1'b1,2'd1, 1'b1,2'd3,16'h0010,2'd3,16'h0306,4'h8);
    tbl[19] = mk(1'b0,1'b1,2'd3,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0012,2'd3,16'h0010,4'h8);
    tbl[20] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd3,16'h0000,2'd3,16'h0012,4'h8);
    tbl[21] = mk(1'b0,1'b1,2'd2,16'h0900, 1'b1,2'd2,16'h0600, 1'b0,2'd0, 1'b1,2'd3,16'h0002,2'd3,16'h0000,4'h8);
    tbl[22] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd2,16'h0600,2'd3,16'h0002,4'hC);
    tbl[23] = mk(1'b1,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd3, 1'b1,2'd3,16'h0004,2'd2,16'h0600,4'hC);
    tbl[24] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b0,2'd3,16'h0004,2'd2,16'h0600,4'h4);
    tbl[25] = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 1'b1,2'd2,16'h0602,2'd2,16'h0600,4'h4);

    // Power-on reset: outputs must take reset values without a clock edge.
    #2 a_rst = 1'b0;
    #1;
    sb.push_back(mke(1'b1, 2'd0, 16'h0000, 2'd0, 16'h0000, 4'h1));
    compare_front("reset_init");
    @(posedge clk);
    #2 a_rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    clear_inputs();
    #1 a_rst = 1'b0;
    #1;
    sb.push_back(mke(1'b1, 2'd0, 16'h0000, 2'd0, 16'h0000, 4'h1));
    compare_front("async_reset");
    @(posedge clk);
    #2 a_rst = 1'b1;

    // Post-reset single-task stream: 0,2,4,6 with prev trailing one cycle.
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = mk(1'b0,1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0,
             1'b1, 2'd0, 16'(2*i), 2'd0, (i == 0) ? 16'h0000 : 16'(2*(i-1)), 4'h1);
      apply(v, $sformatf("post_reset%0d", i));
    end

    @(negedge clk);
    clear_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
